alu_scalar_sequencer: RTL and testbench
=======================================

Name: alu_scalar_sequencer

Overview:
- Issue/writeback front end that drives the 18-bit scalar ALU of the filter GPU.
- Accepts scalar ALU instructions over a valid/ready handshake and reads operands from an internal 16-entry register file.
- Drives the ALU's A/B/F inputs from a registered execute stage, then commits Result to the register file and the flags to an NZCV register.
- Presents each completed operation on a valid/ready writeback port.

Parameters:
- N, 18, datapath width; must match the ALU.
- REGS, 16, register-file depth; power of two.
- RW, 4, register index width, log2(REGS).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  instruction offered
- req_ready  out  1  instruction accepted when req_valid & req_ready at rising clk
- req_op  in  3  ALU F code, forwarded verbatim
- req_rd  in  RW  destination register
- req_ra  in  RW  source register A
- req_rb  in  RW  source register B
- req_use_imm  in  1  1: B operand = req_imm
- req_imm  in  N  immediate
- req_setflags  in  1  commit flags for this instruction
- alu_a  out  N  ALU operand A
- alu_b  out  N  ALU operand B
- alu_f  out  3  ALU function
- alu_result  in  N  ALU Result
- alu_neg, alu_zero, alu_carry, alu_ovf  in  1 each  ALU flags
- wb_valid  out  1  completed operation available
- wb_ready  in  1  consumer accepts
- wb_rd  out  RW  destination of completed op
- wb_data  out  N  result of completed op
- flags_nzcv  out  4  committed {N,Z,C,V}

Behaviour:
- Reset:
  - While rst is high: all RF entries = 0, ex_valid = 0, wb_valid = 0, wb_rd = 0, wb_data = 0, flags_nzcv = 0, alu_a/alu_b/alu_f = 0, req_ready = 0.
  - req_ready = 1 in the first cycle after rst deasserts.
  - rst mid-operation discards any in-flight EX/WB contents; no RF or flags write occurs at that edge.
- Pipeline, accept edge T:
  - Issue in cycle T: EX registers load op, rd, setflags and operands.
  - EX in cycle T+1: alu_a/alu_b/alu_f are driven from the EX registers.
  - WB in cycle T+2: wb_valid = 1.
  - Fixed latency: 2 cycles from accept to wb_valid, with no stalls.
- Operand read:
  - A = RF[ra]; B = req_use_imm ? req_imm : RF[rb].
  - Bypass: if ex_valid, EX is advancing this edge, and ex_rd == ra (or rb) with ex_rd != 0, use alu_result instead of RF.
  - Back-to-back dependent instructions therefore never stall.
- Register 0 always reads 0. Writes to it are dropped from the RF, but the writeback still appears on wb_* with the real result.
- Advance:
  - adv = !(wb_valid && !wb_ready).
  - req_ready = adv and not in reset.
  - EX commits only on an edge with adv = 1. At that edge: RF[ex_rd] <= alu_result; wb_rd/wb_data load; wb_valid <= ex_valid.
- Flags:
  - If ex_setflags, flags_nzcv <= {alu_neg, alu_zero, alu_carry, alu_ovf} at the commit edge, captured verbatim with no reinterpretation.
  - Otherwise flags_nzcv holds its value.
- Stall:
  - While adv = 0, the EX registers hold, so alu_a/alu_b/alu_f stay stable.
  - The RF and flags are not written; the WB outputs hold.
- Idle EX: with ex_valid = 0, alu_a/alu_b/alu_f are driven to 0 and nothing is committed.
- Simultaneous events:
  - An RF write and a read of the same register at the same edge are resolved by the bypass; the read gets the new value.
  - A new accept and a WB drain at the same edge are both permitted.
- Arithmetic: none in this block; all width and overflow semantics belong to the ALU. Results are N bits, unsigned-stored.

Decomposition:
- Shared package alu_pkg:
  - F-code constants: OP_ADD = 3'b000, OP_OR = 3'b001, OP_ADDC = 3'b010, OP_SUB = 3'b011, OP_MUL = 3'b100, OP_PASS = 3'b111.
  - NZCV bit-index constants.
  - A struct typedef for the EX stage: op, rd, a, b, setflags, valid.
- One sub-module: scalar_regfile. It has 2 combinational read ports and 1 synchronous write port, synchronous reset clear, and r0 hardwired to 0.
- Instantiate the aluScalar ALU in the testbench only; it is not inside this block.

Test Plan:
- Add with carry: RF[1] = 18'h3FFFF, RF[2] = 1; op 010, rd = 3, setflags = 1. Expect wb_valid at T+2, wb_data = 0, RF[3] = 0, flags_nzcv = 4'b0110.
- Subtract: RF[1] = 5, imm = 7, op 011, use_imm = 1, setflags = 1. Expect wb_data = 18'h3FFFE and flags_nzcv[3] (N) = 1.
- RAW bypass: back-to-back issue of r4 = imm 10 (op 111), then r5 = r4 + r4 (op 000). Expect req_ready held 1, no bubble, wb_data sequence 10 then 20.
- Back-pressure: hold wb_ready = 0 for 3 cycles with three instructions offered. Expect req_ready = 0 after the pipe fills, alu_* stable, no RF or flags change. On release, all three writebacks occur in order with the correct data.
- r0 and setflags = 0: op 100 with rd = 0, a = 3, b = 4. Expect wb_data = 12 and wb_rd = 0, RF[0] reads 0 afterwards, flags_nzcv unchanged.
- Reset mid-flight: assert rst in the EX cycle of a pending write to r6 = 9. Expect RF[6] = 0, wb_valid = 0, flags_nzcv = 0, and req_ready = 0 during rst then 1 after.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the scalar ALU front end: F codes, NZCV bit positions
// and the execute-stage record.
package alu_pkg;

  localparam int unsigned ALU_N  = 18;
  localparam int unsigned ALU_RW = 4;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADDC = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_MUL  = 3'b100;
  localparam logic [2:0] OP_PASS = 3'b111;

  localparam int unsigned NZCV_N = 3;
  localparam int unsigned NZCV_Z = 2;
  localparam int unsigned NZCV_C = 1;
  localparam int unsigned NZCV_V = 0;

  typedef struct packed {
    logic [2:0]        op;
    logic [ALU_RW-1:0] rd;
    logic [ALU_N-1:0]  a;
    logic [ALU_N-1:0]  b;
    logic              setflags;
    logic              valid;
  } ex_stage_t;

  function automatic logic [3:0] pack_nzcv(input logic n, input logic z,
                                           input logic c, input logic v);
    logic [3:0] f;
    f         = '0;
    f[NZCV_N] = n;
    f[NZCV_Z] = z;
    f[NZCV_C] = c;
    f[NZCV_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/scalar_regfile.sv
// Scalar register file: two combinational read ports, one synchronous write
// port, synchronous clear; register 0 always reads zero and is never written.
module scalar_regfile #(
  parameter int unsigned N    = 18,
  parameter int unsigned REGS = 16,
  parameter int unsigned RW   = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [RW-1:0] waddr_i,
  input  logic [N-1:0]  wdata_i,
  input  logic [RW-1:0] raddr_a_i,
  output logic [N-1:0]  rdata_a_o,
  input  logic [RW-1:0] raddr_b_i,
  output logic [N-1:0]  rdata_b_o
);

  logic [N-1:0] mem_q [REGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: '0};
    end else if (we_i && (waddr_i != '0)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = (raddr_a_i == '0) ? '0 : mem_q[raddr_a_i];
  assign rdata_b_o = (raddr_b_i == '0) ? '0 : mem_q[raddr_b_i];

endmodule

// File: rtl/alu_scalar_sequencer.sv
// Issue/writeback front end for the scalar ALU: issue -> registered EX driving
// the ALU -> commit to RF/NZCV and a valid/ready writeback port.
module alu_scalar_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned N    = 18,
  parameter int unsigned REGS = 16,
  parameter int unsigned RW   = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [2:0]    req_op,
  input  logic [RW-1:0] req_rd,
  input  logic [RW-1:0] req_ra,
  input  logic [RW-1:0] req_rb,
  input  logic          req_use_imm,
  input  logic [N-1:0]  req_imm,
  input  logic          req_setflags,
  output logic [N-1:0]  alu_a,
  output logic [N-1:0]  alu_b,
  output logic [2:0]    alu_f,
  input  logic [N-1:0]  alu_result,
  input  logic          alu_neg,
  input  logic          alu_zero,
  input  logic          alu_carry,
  input  logic          alu_ovf,
  output logic          wb_valid,
  input  logic          wb_ready,
  output logic [RW-1:0] wb_rd,
  output logic [N-1:0]  wb_data,
  output logic [3:0]    flags_nzcv
);

  ex_stage_t     ex_q, ex_d;
  logic          wb_valid_q, wb_valid_d;
  logic [RW-1:0] wb_rd_q, wb_rd_d;
  logic [N-1:0]  wb_data_q, wb_data_d;
  logic [3:0]    flags_q, flags_d;

  logic          adv;
  logic          accept;
  logic          byp_a, byp_b;
  logic          rf_we;
  logic [N-1:0]  rf_a, rf_b;
  logic [N-1:0]  opnd_a, opnd_b;

  scalar_regfile #(
    .N    (N),
    .REGS (REGS),
    .RW   (RW)
  ) u_rf (
    .clk       (clk),
    .rst       (rst),
    .we_i      (rf_we),
    .waddr_i   (ex_q.rd),
    .wdata_i   (alu_result),
    .raddr_a_i (req_ra),
    .rdata_a_o (rf_a),
    .raddr_b_i (req_rb),
    .rdata_b_o (rf_b)
  );

  always_comb begin
    adv       = !(wb_valid_q && !wb_ready);
    req_ready = adv && !rst;
    accept    = req_valid && req_ready;

    // The instruction in EX commits on the same edge the new one issues, so its
    // result is forwarded straight from the ALU instead of the stale RF entry.
    byp_a  = ex_q.valid && adv && (ex_q.rd == req_ra) && (ex_q.rd != '0);
    byp_b  = ex_q.valid && adv && (ex_q.rd == req_rb) && (ex_q.rd != '0);
    opnd_a = byp_a ? alu_result : rf_a;
    if (req_use_imm) begin
      opnd_b = req_imm;
    end else begin
      opnd_b = byp_b ? alu_result : rf_b;
    end

    ex_d       = ex_q;
    wb_valid_d = wb_valid_q;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    flags_d    = flags_q;
    rf_we      = 1'b0;

    if (adv) begin
      ex_d = '0;
      if (accept) begin
        ex_d.op       = req_op;
        ex_d.rd       = req_rd;
        ex_d.a        = opnd_a;
        ex_d.b        = opnd_b;
        ex_d.setflags = req_setflags;
        ex_d.valid    = 1'b1;
      end
      wb_valid_d = ex_q.valid;
      if (ex_q.valid) begin
        rf_we     = 1'b1;
        wb_rd_d   = ex_q.rd;
        wb_data_d = alu_result;
        if (ex_q.setflags) begin
          flags_d = pack_nzcv(alu_neg, alu_zero, alu_carry, alu_ovf);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q       <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      flags_q    <= '0;
    end else begin
      ex_q       <= ex_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      flags_q    <= flags_d;
    end
  end

  assign alu_a      = ex_q.valid ? ex_q.a  : '0;
  assign alu_b      = ex_q.valid ? ex_q.b  : '0;
  assign alu_f      = ex_q.valid ? ex_q.op : '0;
  assign wb_valid   = wb_valid_q;
  assign wb_rd      = wb_rd_q;
  assign wb_data    = wb_data_q;
  assign flags_nzcv = flags_q;

endmodule

// File: tb/tb_alu_scalar_sequencer.sv
// Scoreboard bench for alu_scalar_sequencer with a behavioural 18-bit scalar ALU
// closing the loop; directed vectors carry hand-computed results and flags.
module tb_alu_scalar_sequencer;
  import alu_pkg::*;

  localparam int unsigned N  = 18;
  localparam int unsigned RW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [2:0]    req_op = '0;
  logic [RW-1:0] req_rd = '0;
  logic [RW-1:0] req_ra = '0;
  logic [RW-1:0] req_rb = '0;
  logic          req_use_imm = 1'b0;
  logic [N-1:0]  req_imm = '0;
  logic          req_setflags = 1'b0;
  logic [N-1:0]  alu_a, alu_b;
  logic [2:0]    alu_f;
  logic [N-1:0]  alu_result;
  logic          alu_neg, alu_zero, alu_carry, alu_ovf;
  logic          wb_valid;
  logic          wb_ready = 1'b1;
  logic [RW-1:0] wb_rd;
  logic [N-1:0]  wb_data;
  logic [3:0]    flags_nzcv;

  always #5 clk = ~clk;

  alu_scalar_sequencer #(.N(N), .REGS(16), .RW(RW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rd(req_rd), .req_ra(req_ra), .req_rb(req_rb),
    .req_use_imm(req_use_imm), .req_imm(req_imm), .req_setflags(req_setflags),
    .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f), .alu_result(alu_result),
    .alu_neg(alu_neg), .alu_zero(alu_zero), .alu_carry(alu_carry), .alu_ovf(alu_ovf),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .flags_nzcv(flags_nzcv)
  );

  // Behavioural aluScalar: ADDC takes its carry-in from the committed C flag.
  logic [N:0]     sum;
  logic [2*N-1:0] prod;
  always_comb begin
    sum        = '0;
    prod       = '0;
    alu_result = '0;
    alu_carry  = 1'b0;
    alu_ovf    = 1'b0;
    case (alu_f)
      OP_ADD: begin
        sum        = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result = sum[N-1:0];
        alu_carry  = sum[N];
        alu_ovf    = (alu_a[N-1] == alu_b[N-1]) && (alu_result[N-1] != alu_a[N-1]);
      end
      OP_OR: alu_result = alu_a | alu_b;
      OP_ADDC: begin
        sum        = {1'b0, alu_a} + {1'b0, alu_b} + {{N{1'b0}}, flags_nzcv[NZCV_C]};
        alu_result = sum[N-1:0];
        alu_carry  = sum[N];
        alu_ovf    = (alu_a[N-1] == alu_b[N-1]) && (alu_result[N-1] != alu_a[N-1]);
      end
      OP_SUB: begin
        sum        = {1'b0, alu_a} + {1'b0, ~alu_b} + {{N{1'b0}}, 1'b1};
        alu_result = sum[N-1:0];
        alu_carry  = sum[N];
        alu_ovf    = (alu_a[N-1] != alu_b[N-1]) && (alu_result[N-1] != alu_a[N-1]);
      end
      OP_MUL: begin
        prod       = {{N{1'b0}}, alu_a} * {{N{1'b0}}, alu_b};
        alu_result = prod[N-1:0];
      end
      OP_PASS: alu_result = alu_b;
      default: alu_result = '0;
    endcase
    alu_neg  = alu_result[N-1];
    alu_zero = (alu_result == '0);
  end

  typedef struct {
    logic [RW-1:0] rd;
    logic [N-1:0]  data;
    logic [3:0]    nzcv;
  } exp_t;

  exp_t        sbq[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: every writeback handshake pops one expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && wb_valid && wb_ready) begin
        if (sbq.size() == 0) begin
          n_checks++;
          $display("FAIL wb_unexpected: got rd=%0d data=%0h expected none", wb_rd, wb_data);
        end else begin
          e = sbq.pop_front();
          chk("wb_rd", 32'(wb_rd), 32'(e.rd));
          chk("wb_data", 32'(wb_data), 32'(e.data));
          chk("wb_nzcv", 32'(flags_nzcv), 32'(e.nzcv));
        end
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [RW-1:0] rd,
                       input logic [RW-1:0] ra, input logic [RW-1:0] rb,
                       input logic ui, input logic [N-1:0] imm, input logic sf,
                       input logic push, input logic [N-1:0] ed, input logic [3:0] ef,
                       output int unsigned waits);
    logic rdy;
    logic done;
    exp_t e;
    req_op = op; req_rd = rd; req_ra = ra; req_rb = rb;
    req_use_imm = ui; req_imm = imm; req_setflags = sf;
    req_valid = 1'b1;
    waits = 0;
    done = 1'b0;
    while (!done && waits < 40) begin
      @(negedge clk);
      rdy = req_ready;
      @(posedge clk);
      if (rdy) done = 1'b1;
      else waits++;
    end
    chk("issue_accept", 32'(done), 32'd1);
    if (done && push) begin
      e.rd = rd; e.data = ed; e.nzcv = ef;
      sbq.push_back(e);
    end
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50; i++) begin
      if (sbq.size() == 0) break;
      @(negedge clk);
    end
    chk("drain_empty", 32'(sbq.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int unsigned w;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_rd", 32'(wb_rd), 32'd0);
    chk("rst_wb_data", 32'(wb_data), 32'd0);
    chk("rst_flags", 32'(flags_nzcv), 32'd0);
    chk("rst_alu_abf", 32'({alu_a, alu_b, alu_f} != '0), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;

    // Add with carry: 3FFFF + 1 -> 0, C and Z set
    issue(OP_PASS, 4'd1, 4'd0, 4'd0, 1'b1, 18'h3FFFF, 1'b0, 1'b1, 18'h3FFFF, 4'b0000, w);
    issue(OP_PASS, 4'd2, 4'd0, 4'd0, 1'b1, 18'h00001, 1'b0, 1'b1, 18'h00001, 4'b0000, w);
    drain();
    issue(OP_ADDC, 4'd3, 4'd1, 4'd2, 1'b0, 18'h0, 1'b1, 1'b1, 18'h00000, 4'b0110, w);
    @(negedge clk);
    chk("lat_t1_wb_valid", 32'(wb_valid), 32'd0);
    chk("ex_alu_f", 32'(alu_f), 32'(OP_ADDC));
    chk("ex_alu_a", 32'(alu_a), 32'h3FFFF);
    chk("ex_alu_b", 32'(alu_b), 32'h00001);
    @(negedge clk);
    chk("lat_t2_wb_valid", 32'(wb_valid), 32'd1);
    @(posedge clk); #1;
    issue(OP_PASS, 4'd9, 4'd0, 4'd3, 1'b0, 18'h0, 1'b0, 1'b1, 18'h00000, 4'b0110, w);

    // Subtract with immediate: 5 - 7 -> 3FFFE, N set
    issue(OP_PASS, 4'd1, 4'd0, 4'd0, 1'b1, 18'h00005, 1'b0, 1'b1, 18'h00005, 4'b0110, w);
    issue(OP_SUB, 4'd7, 4'd1, 4'd0, 1'b1, 18'h00007, 1'b1, 1'b1, 18'h3FFFE, 4'b1000, w);

    // RAW bypass, back to back, no bubble
    issue(OP_PASS, 4'd4, 4'd0, 4'd0, 1'b1, 18'd10, 1'b0, 1'b1, 18'd10, 4'b1000, w);
    issue(OP_ADD, 4'd5, 4'd4, 4'd4, 1'b0, 18'h0, 1'b0, 1'b1, 18'd20, 4'b1000, w);
    chk("raw_no_stall", 32'(w), 32'd0);

    // r0 destination, setflags = 0; r0 must still read 0 right after
    issue(OP_PASS, 4'd8, 4'd0, 4'd0, 1'b1, 18'd3, 1'b0, 1'b1, 18'd3, 4'b1000, w);
    issue(OP_MUL, 4'd0, 4'd8, 4'd0, 1'b1, 18'd4, 1'b0, 1'b1, 18'd12, 4'b1000, w);
    issue(OP_PASS, 4'd9, 4'd0, 4'd0, 1'b0, 18'h0, 1'b0, 1'b1, 18'd0, 4'b1000, w);
    issue(OP_PASS, 4'd9, 4'd0, 4'd5, 1'b0, 18'h0, 1'b0, 1'b1, 18'd20, 4'b1000, w);
    drain();

    // Back-pressure
    wb_ready = 1'b0;
    issue(OP_ADD, 4'd10, 4'd8, 4'd0, 1'b1, 18'd1, 1'b1, 1'b1, 18'd4, 4'b0000, w);
    issue(OP_OR, 4'd11, 4'd8, 4'd0, 1'b1, 18'h20000, 1'b1, 1'b1, 18'h20003, 4'b1000, w);
    fork
      issue(OP_SUB, 4'd12, 4'd8, 4'd0, 1'b1, 18'd3, 1'b1, 1'b1, 18'd0, 4'b0110, w);
      begin
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("stall_req_ready", 32'(req_ready), 32'd0);
          chk("stall_alu_a", 32'(alu_a), 32'd3);
          chk("stall_alu_b", 32'(alu_b), 32'h20000);
          chk("stall_alu_f", 32'(alu_f), 32'(OP_OR));
          chk("stall_flags", 32'(flags_nzcv), 32'b0000);
          chk("stall_wb_data", 32'(wb_data), 32'd4);
        end
        @(posedge clk); #1 wb_ready = 1'b1;
      end
    join
    drain();

    // Reset during the EX cycle of a pending r6 = 9
    issue(OP_PASS, 4'd6, 4'd0, 4'd0, 1'b1, 18'd9, 1'b0, 1'b0, 18'd9, 4'b0000, w);
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_req_ready", 32'(req_ready), 32'd0);
    chk("midrst_wb_valid", 32'(wb_valid), 32'd0);
    chk("midrst_flags", 32'(flags_nzcv), 32'd0);
    chk("midrst_alu_b", 32'(alu_b), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("after_rst_ready", 32'(req_ready), 32'd1);
    chk("after_rst_wb_valid", 32'(wb_valid), 32'd0);
    @(posedge clk); #1;
    issue(OP_PASS, 4'd9, 4'd0, 4'd6, 1'b0, 18'h0, 1'b0, 1'b1, 18'd0, 4'b0000, w);
    issue(OP_PASS, 4'd9, 4'd0, 4'd1, 1'b0, 18'h0, 1'b0, 1'b1, 18'd0, 4'b0000, w);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
